// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: round-robin arbiter sharing one ready/valid channel among N
// upstream requesters, with burst locking and a registered output stage.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   up_data[N*DW]     requester i data at bits [i*DW +: DW]
//   up_valid[N]       per-requester valid
//   up_last[N]        per-requester end-of-burst flag (qualified by up_valid)
//   up_ready[N]       per-requester ready (combinational, at most one bit set)
//   down_data[DW]     registered output data
//   down_last         registered last flag
//   down_src          index of the requester that produced the held beat
//   down_valid        output register holds a beat
//   down_ready        downstream accepts the beat
module rv_rr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*DW-1:0]      up_data,
  input  logic [N-1:0]         up_valid,
  input  logic [N-1:0]         up_last,
  output logic [N-1:0]         up_ready,
  output logic [DW-1:0]        down_data,
  output logic                 down_last,
  output logic [$clog2(N)-1:0] down_src,
  output logic                 down_valid,
  input  logic                 down_ready
);

  localparam int unsigned   IW        = $clog2(N);
  localparam logic [3:0]    BURST_LIM = 4'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic          SINGLE    = (MAX_BURST == 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  // Arbitration state
  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;

  // Output register
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic [IW-1:0] src_q, src_d;
  logic          valid_q, valid_d;

  // Combinational arbitration signals
  logic          can_load;
  logic          hi_found, lo_found;
  logic [IW-1:0] hi_idx, lo_idx;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic          xfer;

  // Increment modulo N so non-power-of-2 N never yields an index >= N.
  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] x);
    return (x == LAST_IDX) ? '0 : IW'(x + 1'b1);
  endfunction

  // Rotating priority scan: lowest valid index at or above ptr wins,
  // otherwise wrap to the lowest valid index overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (up_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
  end

  // Grant selection and ready generation; data/last never feed up_ready.
  always_comb begin
    can_load = !valid_q || down_ready;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    if (state_q == S_LOCKED) begin
      // The owner keeps the channel even while its valid is low.
      gnt_vld = 1'b1;
      gnt_idx = owner_q;
    end else if (hi_found) begin
      gnt_vld = 1'b1;
      gnt_idx = hi_idx;
    end else if (lo_found) begin
      gnt_vld = 1'b1;
      gnt_idx = lo_idx;
    end

    up_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      up_ready[i] = !rst && gnt_vld && can_load && (gnt_idx == IW'(i));
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_data = up_data[i*DW +: DW];
        sel_last = up_last[i];
      end
    end
  end

  assign xfer = |(up_valid & up_ready);

  // Next-state logic for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (sel_last || SINGLE) begin
            ptr_d = inc_mod(gnt_idx);
          end else begin
            state_d = S_LOCKED;
            owner_d = gnt_idx;
            cnt_d   = 4'd1;
          end
        end
      end
      S_LOCKED: begin
        if (xfer) begin
          cnt_d = 4'(cnt_q + 4'd1);
          if (sel_last || (cnt_d == BURST_LIM)) begin
            state_d = S_IDLE;
            ptr_d   = inc_mod(owner_q);
          end
        end
      end
    endcase
  end

  // Output register: load on transfer, otherwise drain when accepted.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    src_d   = src_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = sel_data;
      last_d  = sel_last;
      src_d   = gnt_idx;
      valid_d = 1'b1;
    end else if (down_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  assign down_data  = data_q;
  assign down_last  = last_q;
  assign down_src   = src_q;
  assign down_valid = valid_q;

  // Structural invariants of the grant and the stall behaviour.
  a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(up_ready));
  a_stall_hold : assert property (@(posedge clk) disable iff (rst)
    (valid_q && !down_ready) |=> (valid_q && $stable(data_q) && $stable(src_q)));
  a_stall_noready : assert property (@(posedge clk) disable iff (rst)
    (valid_q && !down_ready) |-> (up_ready == '0));

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Testbench for rv_rr_arbiter: directed scenarios followed by randomized
// traffic, checked by a reference model feeding a scoreboard queue.
module tb_rv_rr_arbiter;

  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int IW        = $clog2(N);

  logic              clk;
  logic              rst;
  logic [N*DW-1:0]   up_data;
  logic [N-1:0]      up_valid;
  logic [N-1:0]      up_last;
  logic [N-1:0]      up_ready;
  logic [DW-1:0]     down_data;
  logic              down_last;
  logic [IW-1:0]     down_src;
  logic              down_valid;
  logic              down_ready;

  rv_rr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_last    (up_last),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_last  (down_last),
    .down_src   (down_src),
    .down_valid (down_valid),
    .down_ready (down_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] src;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Stimulus knobs
  logic [N-1:0] en;
  int           pv;
  int           pr;
  int           blen[N];
  int           base[N];
  int           sent[N];

  // Reference model: burst owner (or -1 when arbitrating), rotating
  // pointer, beats in current burst, output register occupancy.
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_occ;
  bit just_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat the downstream accepts must match the oldest expected.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (down_valid === 1'b1 && down_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: got src %0d data %0h expected no beat", down_src, down_data);
        end else begin
          e = q.pop_front();
          check("beat_data", 32'(down_data), 32'(e.data));
          check("beat_last", 32'(down_last), 32'(e.last));
          check("beat_src",  32'(down_src),  32'(e.src));
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      up_valid[i] = en[i] && ($urandom_range(99) < pv);
      up_data[i*DW +: DW] = DW'(base[i] + sent[i]);
      up_last[i] = (blen[i] != 0) && ((sent[i] % blen[i]) == blen[i] - 1);
    end
    down_ready = ($urandom_range(99) < pr);
  endtask

  // One clock: predict and check at the negedge, advance the model at the posedge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    bit has, can_load, xfer;
    int g, idx;
    beat_t b;
    xfer = 1'b0;
    g = 0;
    b = '0;
    @(negedge clk);
    if (rst) begin
      check("up_ready_in_reset", 32'(up_ready), 32'd0);
    end else begin
      can_load = !m_occ || down_ready;
      has = 1'b0;
      if (m_owner >= 0) begin
        has = 1'b1;
        g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!has && up_valid[idx]) begin
            has = 1'b1;
            g = idx;
          end
        end
      end
      exp_rdy = '0;
      if (has && can_load) exp_rdy[g] = 1'b1;
      check("up_ready", 32'(up_ready), 32'(exp_rdy));
      check("down_valid", 32'(down_valid), 32'(m_occ));
      if (just_rst) begin
        check("rst_down_data", 32'(down_data), 32'd0);
        check("rst_down_last", 32'(down_last), 32'd0);
        check("rst_down_src",  32'(down_src),  32'd0);
        just_rst = 1'b0;
      end
      xfer = has && can_load && up_valid[g];
      b.data = up_data[g*DW +: DW];
      b.last = up_last[g];
      b.src  = IW'(g);
    end
    @(posedge clk);
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_occ   = 1'b0;
      just_rst = 1'b1;
      q.delete();
    end else if (xfer) begin
      q.push_back(b);
      m_occ = 1'b1;
      sent[g]++;
      if (m_owner < 0) begin
        if (b.last || MAX_BURST == 1) begin
          m_ptr = (g + 1) % N;
        end else begin
          m_owner = g;
          m_cnt   = 1;
        end
      end else begin
        m_cnt++;
        if (b.last || m_cnt == MAX_BURST) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else if (down_ready) begin
      m_occ = 1'b0;
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      tick();
    end
  endtask

  task automatic set_all(input int bl, input int bs);
    for (int i = 0; i < N; i++) begin
      blen[i] = bl;
      base[i] = bs + i;
      sent[i] = 0;
    end
  endtask

  initial begin
    m_owner = -1;
    m_ptr = 0;
    m_cnt = 0;
    m_occ = 1'b0;
    just_rst = 1'b0;
    up_data = '0;
    up_valid = '0;
    up_last = '0;
    down_ready = 1'b0;

    // Reset with every requester valid.
    rst = 1'b1;
    en = '1; pv = 100; pr = 100;
    set_all(1, 8'h10);
    run(2);
    rst = 1'b0;

    // Round-robin, single-beat bursts.
    set_all(1, 8'h10);
    run(6);

    // Burst lock: requester 2 sends three beats, requester 1 waits.
    set_all(1, 8'h10);
    en = 4'b0110; blen[2] = 3; base[2] = 8'hA0;
    run(8);

    // Burst limit: requester 0 never sends last, requester 3 is valid.
    set_all(1, 8'h30);
    en = 4'b1001; blen[0] = 0;
    run(12);

    // Backpressure: 0x55 held while downstream stalls for three cycles.
    en = '0; pr = 100;
    run(3);
    set_all(1, 8'h55);
    en = 4'b0001; pr = 0;
    run(4);
    pr = 100;
    run(3);

    // Owner bubble then reset mid-burst.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    set_all(6, 8'h60);
    en = 4'b0110;
    run(2);
    en = 4'b0100;
    run(2);
    en = 4'b0110;
    run(1);
    en = 4'b0111;
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(4);

    // Randomized traffic with occasional resets.
    for (int ph = 0; ph < 30; ph++) begin
      en = N'($urandom_range(1, (1 << N) - 1));
      pv = $urandom_range(30, 100);
      pr = $urandom_range(20, 100);
      for (int i = 0; i < N; i++) begin
        blen[i] = $urandom_range(0, 5);
        base[i] = $urandom_range(0, 255);
      end
      run(40);
      if ($urandom_range(3) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end
      run(30);
    end

    // Drain and confirm every expected beat was delivered.
    en = '0; pr = 100;
    run(4);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
